// File: rtl/serial_word_deserializer.sv
// serial_word_deserializer
//
// Collects a framed serial bit stream into BITS-wide parallel words and
// buffers completed words in a small FIFO behind a valid/ready handshake.
// Bit order (MSB-first or LSB-first) is chosen per frame with dirIn, which
// is sampled together with frameStart.
//
// Optional feature: define SERIAL_PARITY_CHECK_EN to expect one even-parity
// bit after the BITS data bits of every frame. Frames with bad parity are
// dropped and reported on the extra parityErr pulse output.
//
// Ports:
//   clk        clock
//   reset_n    asynchronous active-low reset
//   serIn      serial data bit
//   serValid   serIn is sampled this cycle
//   frameStart current serIn is bit 0 of a new word (with serValid=1)
//   dirIn      bit order, sampled with frameStart: 0 = MSB first, 1 = LSB first
//   outReady   consumer accepts dataOut this cycle
//   clrOvf     clears the sticky overflow flag
//   dataOut    head-of-FIFO word (holds last value while empty)
//   outValid   FIFO non-empty
//   overflow   sticky: a completed word was dropped because the FIFO was full
//   frameErr   1-cycle pulse: a frame restarted before the word completed
//   parityErr  1-cycle pulse: parity mismatch, word dropped (parity build only)

module serial_word_deserializer #(
  parameter int BITS       = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            serIn,
  input  logic            serValid,
  input  logic            frameStart,
  input  logic            dirIn,
  input  logic            outReady,
  input  logic            clrOvf,
  output logic [BITS-1:0] dataOut,
  output logic            outValid,
  output logic            overflow,
`ifdef SERIAL_PARITY_CHECK_EN
  output logic            parityErr,
`endif
  output logic            frameErr
);

`ifdef SERIAL_PARITY_CHECK_EN
  localparam int FRAME_LEN = BITS + 1;
`else
  localparam int FRAME_LEN = BITS;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  // ---------------------------------------------------------------------
  // Frame assembly
  // ---------------------------------------------------------------------
  state_t            state_reg, state_next;
  logic [BITS-1:0]   shift_reg, shift_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              dir_reg, dir_next;
  logic              frame_err_reg, frame_err_next;
  logic              parity_err_next;
  logic [BITS-1:0]   shifted;
  logic [BITS-1:0]   push_word;
  logic              push;

  // Register contents with the current serial bit shifted in using the
  // latched bit order of the frame in progress.
  assign shifted = dir_reg ? {serIn, shift_reg[BITS-1:1]}
                           : {shift_reg[BITS-2:0], serIn};

  always_comb begin
    state_next      = state_reg;
    shift_next      = shift_reg;
    count_next      = count_reg;
    dir_next        = dir_reg;
    frame_err_next  = 1'b0;
    parity_err_next = 1'b0;
    push            = 1'b0;
`ifdef SERIAL_PARITY_CHECK_EN
    push_word       = shift_reg;
`else
    push_word       = shifted;
`endif

    if (serValid && frameStart) begin
      // A start while SHIFT is active throws away the partial word; the
      // bit still begins a fresh frame so no data cycle is lost.
      frame_err_next = (state_reg == SHIFT);
      dir_next       = dirIn;
      shift_next     = dirIn ? {serIn, {(BITS-1){1'b0}}}
                             : {{(BITS-1){1'b0}}, serIn};
      count_next     = CNT_W'(1);
      state_next     = SHIFT;
    end else if (serValid && (state_reg == SHIFT)) begin
      // Data bits go into the shift register; a trailing parity bit does not.
      if (count_reg < CNT_W'(BITS)) begin
        shift_next = shifted;
      end
      count_next = count_reg + CNT_W'(1);
      if (count_reg == CNT_W'(FRAME_LEN - 1)) begin
        state_next = IDLE;
        count_next = '0;
`ifdef SERIAL_PARITY_CHECK_EN
        // Even parity: data ones plus the parity bit must be even.
        if (serIn == ^shift_reg) begin
          push = 1'b1;
        end else begin
          parity_err_next = 1'b1;
        end
`else
        push = 1'b1;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------
  logic [BITS-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   fill;
  logic [PTR_W-1:0] rd_idx_after;
  logic             fifo_empty, fifo_full;
  logic             pop, push_ok, ovf_set;
  logic [BITS-1:0]  data_out_reg, data_out_next;
  logic             overflow_reg;

  assign fifo_empty   = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                        (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign fill         = wr_ptr_reg - rd_ptr_reg;
  assign rd_idx_after = rd_ptr_reg[PTR_W-1:0] + PTR_W'(1);

  assign pop     = !fifo_empty && outReady;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok = push && (!fifo_full || pop);
  assign ovf_set = push && fifo_full && !pop;

  // dataOut is a register holding the head word, so it can keep its last
  // value once the FIFO drains instead of exposing a stale RAM slot.
  always_comb begin
    data_out_next = data_out_reg;
    if (pop) begin
      if (fill > (PTR_W+1)'(1)) begin
        data_out_next = mem[rd_idx_after];
      end else if (push_ok) begin
        data_out_next = push_word;
      end
    end else if (fifo_empty && push_ok) begin
      data_out_next = push_word;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[PTR_W-1:0]] <= push_word;
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
`ifdef SERIAL_PARITY_CHECK_EN
  logic parity_err_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_err_reg <= 1'b0;
    end else begin
      parity_err_reg <= parity_err_next;
    end
  end

  assign parityErr = parity_err_reg;
`else
  logic unused_parity;
  assign unused_parity = parity_err_next;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      count_reg     <= '0;
      dir_reg       <= 1'b0;
      frame_err_reg <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      data_out_reg  <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      count_reg     <= count_next;
      dir_reg       <= dir_next;
      frame_err_reg <= frame_err_next;
      data_out_reg  <= data_out_next;
      // A fresh overflow wins over a simultaneous clear.
      overflow_reg  <= ovf_set || (overflow_reg && !clrOvf);
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + (PTR_W+1)'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + (PTR_W+1)'(1);
      end
    end
  end

  assign dataOut  = data_out_reg;
  assign outValid = !fifo_empty;
  assign overflow = overflow_reg;
  assign frameErr = frame_err_reg;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Self-checking bench for serial_word_deserializer: directed frames with
// literal expectations plus a randomized phase, all compared every cycle
// against a queue-based model of frames and the output FIFO.

module tb_serial_word_deserializer;

  localparam int BITS  = 8;
  localparam int DEPTH = 2;
`ifdef SERIAL_PARITY_CHECK_EN
  localparam int FLEN = BITS + 1;
`else
  localparam int FLEN = BITS;
`endif

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            ser_in = 1'b0;
  logic            ser_valid = 1'b0;
  logic            frame_start = 1'b0;
  logic            dir_in = 1'b0;
  logic            out_ready = 1'b0;
  logic            clr_ovf = 1'b0;
  logic [BITS-1:0] data_out;
  logic            out_valid;
  logic            overflow;
  logic            frame_err;
  logic            parity_err;

  serial_word_deserializer #(.BITS(BITS), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .serIn      (ser_in),
    .serValid   (ser_valid),
    .frameStart (frame_start),
    .dirIn      (dir_in),
    .outReady   (out_ready),
    .clrOvf     (clr_ovf),
    .dataOut    (data_out),
    .outValid   (out_valid),
    .overflow   (overflow),
`ifdef SERIAL_PARITY_CHECK_EN
    .parityErr  (parity_err),
`endif
    .frameErr   (frame_err)
  );

`ifndef SERIAL_PARITY_CHECK_EN
  assign parity_err = 1'b0;
`endif

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Behavioural model: bits of the open frame as a queue, words as a queue
  // ------------------------------------------------------------------
  bit              m_bits[$];
  bit              m_in_frame;
  bit              m_dir;
  logic [BITS-1:0] m_fifo[$];
  logic [BITS-1:0] m_last;
  logic [BITS-1:0] m_word;
  bit              m_ovf, m_ferr, m_perr, m_push, m_pop, m_ovf_set;
  int              m_ones;

  always begin
    @(posedge clk);
    if (!reset_n) begin
      m_bits.delete();
      m_fifo.delete();
      m_in_frame = 0;
      m_dir      = 0;
      m_last     = '0;
      m_ovf      = 0;
      m_ferr     = 0;
      m_perr     = 0;
    end else begin
      m_pop     = (m_fifo.size() > 0) && out_ready;
      m_ferr    = 0;
      m_perr    = 0;
      m_push    = 0;
      m_ovf_set = 0;
      if (ser_valid) begin
        if (frame_start) begin
          m_ferr = m_in_frame;
          m_bits.delete();
          m_bits.push_back(ser_in);
          m_dir      = dir_in;
          m_in_frame = 1;
        end else if (m_in_frame) begin
          m_bits.push_back(ser_in);
        end
        if (m_in_frame && m_bits.size() == FLEN) begin
          m_word = '0;
          m_ones = 0;
          for (int i = 0; i < BITS; i++)
            m_word[m_dir ? i : BITS-1-i] = m_bits[i];
          for (int i = 0; i < FLEN; i++)
            m_ones += int'(m_bits[i]);
          if (FLEN == BITS || (m_ones % 2) == 0) m_push = 1;
          else m_perr = 1;
          m_in_frame = 0;
        end
      end
      if (m_pop) void'(m_fifo.pop_front());
      if (m_push) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(m_word);
        else m_ovf_set = 1;
      end
      m_ovf = (m_ovf && !clr_ovf) || m_ovf_set;
      if (m_fifo.size() > 0) m_last = m_fifo[0];
    end
    #1;
    chk("outValid", 32'(out_valid), 32'(m_fifo.size() > 0));
    chk("dataOut", 32'(data_out), 32'(m_last));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("frameErr", 32'(frame_err), 32'(m_ferr));
    chk("parityErr", 32'(parity_err), 32'(m_perr));
  end

  // ------------------------------------------------------------------
  // Stimulus helpers: inputs change 2 time units after the rising edge
  // ------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    ser_valid   = 0;
    frame_start = 0;
    repeat (n) tick();
  endtask

  task automatic send_bit(input bit b, input bit start, input bit dir);
    ser_valid   = 1;
    ser_in      = b;
    frame_start = start;
    dir_in      = dir;
    tick();
    ser_valid   = 0;
    frame_start = 0;
    ser_in      = ~b;
    dir_in      = ~dir;
  endtask

  task automatic send_word(input logic [BITS-1:0] w, input bit dir, input int from = 0,
                           input int gap_at = -1, input bit bad_par = 0,
                           input bit ready_last = 0);
    for (int i = from; i < BITS; i++) begin
      if (i == gap_at) idle(3);
      if (ready_last && i == FLEN-1) out_ready = 1;
      send_bit(w[dir ? i : BITS-1-i], i == 0, dir);
    end
`ifdef SERIAL_PARITY_CHECK_EN
    if (ready_last) out_ready = 1;
    send_bit((^w) ^ bad_par, 1'b0, dir);
`else
    if (bad_par) ser_in = 0;
`endif
  endtask

  initial begin
    #2;
    tick();
    chk("reset outValid", 32'(out_valid), 0);
    chk("reset dataOut", 32'(data_out), 0);
    chk("reset overflow", 32'(overflow), 0);
    tick();
    reset_n = 1;
    tick();

    // 1: MSB-first 0xA5, single beat
    out_ready = 1;
    send_word(8'hA5, 0);
    chk("t1 data", 32'(data_out), 32'h A5);
    chk("t1 valid", 32'(out_valid), 1);
    idle(1);
    chk("t1 drained", 32'(out_valid), 0);

    // 2: LSB-first 0x1E with a 3-cycle gap before bit 4
    send_word(8'h1E, 1, 0, 4);
    chk("t2 data", 32'(data_out), 32'h1E);
    chk("t2 valid", 32'(out_valid), 1);
    idle(2);

    // 3: overflow on the third back-to-back word
    out_ready = 0;
    send_word(8'h11, 0);
    send_word(8'h22, 0);
    send_word(8'h33, 0);
    chk("t3 overflow", 32'(overflow), 1);
    chk("t3 head", 32'(data_out), 32'h11);
    out_ready = 1;
    tick();
    chk("t3 second", 32'(data_out), 32'h22);
    tick();
    chk("t3 empty", 32'(out_valid), 0);
    clr_ovf = 1;
    tick();
    clr_ovf = 0;
    chk("t3 cleared", 32'(overflow), 0);

    // 4: abort after 4 bits of 0xF0, then 0x5A
    for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0);
    chk("t4 frameErr", 32'(frame_err), 1);
    send_bit(1'b1, 1'b0, 1'b0);
    chk("t4 frameErr pulse", 32'(frame_err), 0);
    send_word(8'h5A, 0, 2);
    chk("t4 data", 32'(data_out), 32'h5A);
    idle(2);

    // 5: full FIFO with a pop on the completing edge
    out_ready = 0;
    send_word(8'h3C, 0);
    send_word(8'h96, 1);
    send_word(8'h7E, 0, 0, -1, 0, 1);
    chk("t5 overflow", 32'(overflow), 0);
    chk("t5 head", 32'(data_out), 32'h96);
    tick();
    chk("t5 tail", 32'(data_out), 32'h7E);
    idle(2);

    // 6: async reset mid-frame
    for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0, 1'b0);
    reset_n = 0;
    #1;
    chk("t6 async dataOut", 32'(data_out), 0);
    chk("t6 async valid", 32'(out_valid), 0);
    idle(2);
    reset_n = 1;
    tick();
    send_word(8'hC3, 0);
    chk("t6 data", 32'(data_out), 32'hC3);
    idle(2);
`ifdef SERIAL_PARITY_CHECK_EN
    send_word(8'hC3, 0, 0, -1, 1);
    chk("t6 parityErr", 32'(parity_err), 1);
    chk("t6 no push", 32'(out_valid), 0);
    idle(2);
`endif

    // Randomized phase
    for (int n = 0; n < 4000; n++) begin
      ser_valid   = ($urandom_range(0, 3) != 0);
      frame_start = ($urandom_range(0, 11) == 0);
      ser_in      = 1'($urandom);
      dir_in      = 1'($urandom);
      out_ready   = (n < 2000) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
      clr_ovf     = ($urandom_range(0, 19) == 0);
      tick();
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
